// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
//
// Game-flow controller. Conditions six raw push-buttons (two-flop
// synchroniser, counter debouncer, rising-edge press detector) and runs the
// game state machine  none -> load -> activate <-> pause -> terminate.
//
// Ports
//   clk          in   system clock (only clock)
//   clr          in   asynchronous active-low reset
//   btn_start    in   raw button, active-high, asynchronous
//   btn_pause    in   raw button, active-high, asynchronous
//   btn_up       in   raw button, active-high, asynchronous
//   btn_down     in   raw button, active-high, asynchronous
//   btn_left     in   raw button, active-high, asynchronous
//   btn_right    in   raw button, active-high, asynchronous
//   crash        in   synchronous collision flag, sampled every cycle
//   status       out  one-hot game state (load 1000, activate 0100,
//                     pause 0010, terminate 0001, none 0000), registered
//   direction    out  {up, down, left, right}, at most one bit set,
//                     registered, non-zero only while in activate
//   restart      out  one-cycle pulse on load -> activate, registered
// ---------------------------------------------------------------------------
module game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SPLASH_CYCLES   = 200_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       crash,
  output logic [3:0] status,
  output logic [3:0] direction,
  output logic       restart
);

  // Button indices inside the conditioned vectors.
  localparam int NBTN    = 6;
  localparam int B_START = 0;
  localparam int B_PAUSE = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;
  localparam int B_LEFT  = 4;
  localparam int B_RIGHT = 5;

  // Counter widths; the debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SPLASH_CYCLES > 1) ? $clog2(SPLASH_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SPLASH_MAX = SW'(SPLASH_CYCLES - 1);

  // State encodings double as the status bus, so status is the state register.
  typedef enum logic [3:0] {
    ST_NONE  = 4'b0000,
    ST_LOAD  = 4'b1000,
    ST_ACT   = 4'b0100,
    ST_PAUSE = 4'b0010,
    ST_TERM  = 4'b0001
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0]         btn_raw_s;
  logic [NBTN-1:0]         sync1_q, sync1_d;
  logic [NBTN-1:0]         sync2_q, sync2_d;
  logic [NBTN-1:0]         deb_q,   deb_d;
  logic [NBTN-1:0]         prev_q,  prev_d;
  logic [NBTN-1:0][DW-1:0] cnt_q,   cnt_d;
  logic [NBTN-1:0]         press_s;

  assign btn_raw_s = {btn_right, btn_left, btn_down, btn_up, btn_pause, btn_start};

  // A press is the first cycle the debounced level is seen high.
  assign press_s = deb_q & ~prev_q;

  // Debounce next-state: count while the synchronised and debounced levels
  // disagree, flip the debounced level once they have disagreed long enough.
  always_comb begin
    sync1_d = btn_raw_s;
    sync2_d = sync1_q;
    prev_d  = deb_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NBTN; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  // Conditioning registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Game state machine
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [SW-1:0]   splash_q, splash_d;
  logic            restart_q, restart_d;
  logic [3:0]      direction_q, direction_d;

  // Fixed priority up > down > left > right, one-hot result.
  function automatic logic [3:0] dir_prio(input logic up, input logic down,
                                          input logic left, input logic right);
    logic [3:0] r;
    if (up) begin
      r = 4'b1000;
    end else if (down) begin
      r = 4'b0100;
    end else if (left) begin
      r = 4'b0010;
    end else if (right) begin
      r = 4'b0001;
    end else begin
      r = 4'b0000;
    end
    return r;
  endfunction

  // Next-state and next-output logic. Presses not consumed by the current
  // state are simply dropped, so nothing is queued.
  always_comb begin
    state_d     = state_q;
    splash_d    = splash_q;
    restart_d   = 1'b0;
    direction_d = 4'b0000;

    case (state_q)
      ST_NONE: begin
        if (splash_q == SPLASH_MAX) begin
          state_d  = ST_LOAD;
          splash_d = '0;
        end else begin
          splash_d = splash_q + SW'(1);
        end
      end
      ST_LOAD: begin
        if (press_s[B_START]) begin
          state_d   = ST_ACT;
          restart_d = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_ACT: begin
        // Crash outranks a simultaneous pause press.
        if (crash) begin
          state_d = ST_TERM;
        end else if (press_s[B_PAUSE]) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_ACT;
        end
      end
      ST_PAUSE: begin
        if (press_s[B_PAUSE]) begin
          state_d = ST_ACT;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_TERM: begin
        if (press_s[B_START]) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_TERM;
        end
      end
      default: begin
        state_d  = ST_NONE;
        splash_d = '0;
      end
    endcase

    // Keyed on the next state so direction clears on the same edge that
    // status leaves activate.
    if (state_d == ST_ACT) begin
      direction_d = dir_prio(deb_q[B_UP], deb_q[B_DOWN], deb_q[B_LEFT], deb_q[B_RIGHT]);
    end else begin
      direction_d = 4'b0000;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_NONE;
      splash_q    <= '0;
      restart_q   <= 1'b0;
      direction_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      splash_q    <= splash_d;
      restart_q   <= restart_d;
      direction_q <= direction_d;
    end
  end

  assign status    = state_q;
  assign direction = direction_q;
  assign restart   = restart_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl with DEBOUNCE_CYCLES = 4, SPLASH_CYCLES = 10.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "edge k" means the k-th rising edge after the input change.
module tb_game_ctrl;

  logic       clk;
  logic       clr;
  logic       btn_start, btn_pause, btn_up, btn_down, btn_left, btn_right;
  logic       crash;
  logic [3:0] status;
  logic [3:0] direction;
  logic       restart;

  int errors = 0;
  int checks = 0;

  game_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SPLASH_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .crash    (crash),
    .status   (status),
    .direction(direction),
    .restart  (restart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] st, input logic [3:0] dir,
                           input logic rs);
    check({tag, ".status"}, status, st);
    check({tag, ".direction"}, direction, dir);
    check({tag, ".restart"}, {3'b000, restart}, {3'b000, rs});
  endtask

  initial begin
    clr = 1'b0;
    btn_start = 1'b0; btn_pause = 1'b0; btn_up = 1'b0;
    btn_down = 1'b0;  btn_left = 1'b0;  btn_right = 1'b0;
    crash = 1'b0;

    // 1. Reset and splash
    wait_ticks(3);
    check_out("reset", 4'b0000, 4'b0000, 1'b0);
    clr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k < 10) check_out("splash", 4'b0000, 4'b0000, 1'b0);
      else        check_out("splash_end", 4'b1000, 4'b0000, 1'b0);
    end

    // 2. Start path, button held
    btn_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 7)       check_out("start_wait", 4'b1000, 4'b0000, 1'b0);
      else if (k == 7) check_out("start_edge", 4'b0100, 4'b0000, 1'b1);
      else             check_out("start_after", 4'b0100, 4'b0000, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      check_out("start_held", 4'b0100, 4'b0000, 1'b0);
    end
    btn_start = 1'b0;
    wait_ticks(8);
    check_out("start_release", 4'b0100, 4'b0000, 1'b0);

    // 3. Debounce rejection, then real pause / resume
    btn_pause = 1'b1;
    wait_ticks(3);
    btn_pause = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch.status", status, 4'b0100);
    end
    btn_pause = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k < 7) check("pause_wait.status", status, 4'b0100);
      else       check_out("pause_in", 4'b0010, 4'b0000, 1'b0);
    end
    btn_pause = 1'b0;
    wait_ticks(8);
    check("pause_release.status", status, 4'b0010);
    btn_pause = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 7) check_out("resume_wait", 4'b0010, 4'b0000, 1'b0);
      else       check_out("resume", 4'b0100, 4'b0000, 1'b0);
    end
    btn_pause = 1'b0;
    wait_ticks(8);

    // 4. Crash beats a simultaneous pause press
    btn_pause = 1'b1;
    wait_ticks(6);
    check("crash_pre.status", status, 4'b0100);
    crash = 1'b1;
    tick();
    crash = 1'b0;
    check_out("crash", 4'b0001, 4'b0000, 1'b0);
    btn_pause = 1'b0;
    wait_ticks(8);
    check("term_hold.status", status, 4'b0001);
    btn_start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) check("term_wait.status", status, 4'b0001);
      else       check_out("term_to_load", 4'b1000, 4'b0000, 1'b0);
    end
    btn_start = 1'b0;
    wait_ticks(8);

    // Back into activate for the direction tests
    btn_start = 1'b1;
    wait_ticks(7);
    check_out("reactivate", 4'b0100, 4'b0000, 1'b1);
    btn_start = 1'b0;
    wait_ticks(8);

    // 5. Direction priority
    btn_up = 1'b1;
    btn_left = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) check("dir_wait.direction", direction, 4'b0000);
      else       check("dir_up_left.direction", direction, 4'b1000);
    end
    btn_up = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) check("dir_up_hold.direction", direction, 4'b1000);
      else       check("dir_left.direction", direction, 4'b0010);
    end
    btn_pause = 1'b1;
    wait_ticks(6);
    check_out("dir_pre_pause", 4'b0100, 4'b0010, 1'b0);
    tick();
    check_out("dir_pause", 4'b0010, 4'b0000, 1'b0);

    // 6. Mid-game reset with right held
    btn_right = 1'b1;
    wait_ticks(8);
    check_out("pause_right", 4'b0010, 4'b0000, 1'b0);
    #2;
    clr = 1'b0;
    #1;
    check_out("async_reset", 4'b0000, 4'b0000, 1'b0);
    tick();
    clr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k < 10) check_out("resplash", 4'b0000, 4'b0000, 1'b0);
      else        check_out("resplash_end", 4'b1000, 4'b0000, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
